ofdm_tx_rate_pacer: RTL

//  Sits directly downstream of the OFDM cyclic-prefix adder. That stage emits CP-prefixed

---
 rtl/ofdm_tx_rate_pacer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ofdm_tx_rate_pacer.sv
// rtl/ofdm_tx_rate_pacer.sv - FIFO-buffered fixed-rate replay of CP-prefixed OFDM samples to the DAC
//
// Purpose:
//   Absorbs bursty, non-stallable samples from the cyclic-prefix adder into a FIFO.
//   Replays them to the DAC at one sample every RATE_DIV clocks, and outputs zeros
//   between frames. Dropped writes and mid-frame starvation are flagged.
//
// Ports:
//   clk_clk          in   single clock
//   reset_reset      in   synchronous active-high reset
//   in_data          in   DATA_W sample {I,Q}
//   in_valid         in   write strobe (no backpressure)
//   in_startofpacket in   first sample of frame
//   in_endofpacket   in   last sample of frame
//   clear_status     in   pulse, clears sticky flags
//   dac_data         out  registered sample to DAC
//   dac_strobe       out  one-cycle pulse per output slot
//   dac_active       out  high while playing a frame
//   overflow_sticky  out  a write was dropped on a full FIFO
//   underflow_sticky out  FIFO ran empty inside a frame
//   fill_level       out  FIFO occupancy
module ofdm_tx_rate_pacer #(
  parameter int DATA_W       = 22,
  parameter int FIFO_DEPTH   = 256,
  parameter int RATE_DIV     = 4,
  parameter int START_THRESH = 80
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  input  logic                          in_startofpacket,
  input  logic                          in_endofpacket,
  input  logic                          clear_status,
  output logic [DATA_W-1:0]             dac_data,
  output logic                          dac_strobe,
  output logic                          dac_active,
  output logic                          overflow_sticky,
  output logic                          underflow_sticky,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RATE_DIV);
  localparam logic [AW:0]   FULL_LVL   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   THRESH_LVL = (AW+1)'(START_THRESH);
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(RATE_DIV-1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {IDLE, PLAY, UFLUSH} state_t;

  logic [DATA_W+1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [AW:0]       eop_cnt_q, eop_cnt_d;
  logic [CW-1:0]     cnt_q;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] dac_data_q;
  logic              strobe_q, oflow_q, uflow_q;

  logic [DATA_W+1:0] head;
  logic [DATA_W-1:0] head_data;
  logic              head_sop, head_eop;
  logic              empty, full, tick, push, pop;
  logic              load, uflow_set, oflow_set;
  logic [DATA_W-1:0] load_val;

  assign head      = mem_q[rd_ptr_q];
  assign head_data = head[DATA_W-1:0];
  assign head_eop  = head[DATA_W];
  assign head_sop  = head[DATA_W+1];
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_LVL);
  assign tick      = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    uflow_set = 1'b0;
    case (state_q)
      IDLE: begin
        load = tick;
        if (!empty) begin
          // Anything not starting a frame is stale: drop it to resync on the next sop.
          if (!head_sop) pop = 1'b1;
          else if (count_q >= THRESH_LVL || eop_cnt_q != '0) state_d = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          load = 1'b1;
          if (!empty) begin
            pop      = 1'b1;
            load_val = head_data;
            if (head_eop) state_d = IDLE;
          end else begin
            uflow_set = 1'b1;
            state_d   = UFLUSH;
          end
        end
      end
      UFLUSH: begin
        load = tick;
        if (!empty) begin
          if (head_eop) begin
            pop     = 1'b1;
            state_d = IDLE;
          end else if (head_sop) begin
            // A fresh frame begins before the broken one's eop; keep it for IDLE.
            state_d = IDLE;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a write when a word leaves in the same cycle.
  assign push      = in_valid && (!full || pop);
  assign oflow_set = in_valid && full && !pop;

  always_comb begin
    count_d   = count_q;
    eop_cnt_d = eop_cnt_q;
    if (push && !pop) count_d = count_q + LVL_ONE;
    if (pop && !push) count_d = count_q - LVL_ONE;
    if ((push && in_endofpacket) && !(pop && head_eop)) eop_cnt_d = eop_cnt_q + LVL_ONE;
    if (!(push && in_endofpacket) && (pop && head_eop)) eop_cnt_d = eop_cnt_q - LVL_ONE;
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_startofpacket, in_endofpacket, in_data};
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      eop_cnt_q  <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      dac_data_q <= '0;
      strobe_q   <= 1'b0;
      oflow_q    <= 1'b0;
      uflow_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q   <= count_d;
      eop_cnt_q <= eop_cnt_d;
      cnt_q     <= tick ? '0 : cnt_q + CNT_ONE;
      strobe_q  <= tick;
      state_q   <= state_d;
      if (load) dac_data_q <= load_val;
      // A new event in the same cycle as a clear keeps the flag set.
      if (oflow_set)         oflow_q <= 1'b1;
      else if (clear_status) oflow_q <= 1'b0;
      if (uflow_set)         uflow_q <= 1'b1;
      else if (clear_status) uflow_q <= 1'b0;
    end
  end

  assign dac_data         = dac_data_q;
  assign dac_strobe       = strobe_q;
  assign dac_active       = (state_q == PLAY);
  assign overflow_sticky  = oflow_q;
  assign underflow_sticky = uflow_q;
  assign fill_level       = count_q;

endmodule
